// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO of {pc, inst} pairs with valid/ready on both sides and synchronous flush.
// Optional cycle counters for full/empty stalls are built when IFQ_PERF_EN is defined.
module if_id_queue #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PC_W-1:0]              in_pc,
    input  logic [INST_W-1:0]            in_inst,
    input  logic                         flush,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [PC_W-1:0]              id_pc,
    output logic [INST_W-1:0]            id_inst,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         fetch_stall_req
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]                  perf_full_cyc,
    output logic [31:0]                  perf_empty_cyc
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]   r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;

    logic w_push;
    logic w_pop;

    // Handshakes depend only on registered occupancy and flush, never on the other side.
    assign in_ready = (r_cnt != FULL_CNT) && !flush;
    assign id_valid = (r_cnt != '0) && !flush;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = id_valid && id_ready;

    assign id_pc           = id_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign id_inst         = id_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign count           = r_cnt;
    assign fetch_stall_req = !rst && (r_cnt == '0) && !in_valid;

    // NOTE: storage has no reset; only pointers and count define validity, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= in_pc;
            r_mem_inst[r_wr_ptr] <= in_inst;
        end
    end

    // Flush and reset both empty the queue; w_push/w_pop are already masked by flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef IFQ_PERF_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_empty;
    logic        w_full_blk;
    logic        w_empty_req;

    assign w_full_blk  = in_valid && !in_ready && !flush;
    assign w_empty_req = (r_cnt == '0) && id_ready;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full  <= '0;
            r_perf_empty <= '0;
        end else begin
            if (w_full_blk && (r_perf_full != '1))   r_perf_full  <= r_perf_full + 1'b1;
            if (w_empty_req && (r_perf_empty != '1)) r_perf_empty <= r_perf_empty + 1'b1;
        end
    end

    assign perf_full_cyc  = r_perf_full;
    assign perf_empty_cyc = r_perf_empty;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: vector table plus wrap-around and perf-counter sequences.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;
    logic        fetch_stall_req;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_full_cyc;
    logic [31:0] perf_empty_cyc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_id_queue #(.PC_W(64), .INST_W(32), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_inst         (in_inst),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .count           (count),
        .fetch_stall_req (fetch_stall_req)
`ifdef IFQ_PERF_EN
        ,
        .perf_full_cyc   (perf_full_cyc),
        .perf_empty_cyc  (perf_empty_cyc)
`endif
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic        fl;
        logic        idr;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        e_inr;
        logic        e_idv;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_cnt;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic iv, input logic fl, input logic idr,
                                input logic [63:0] pc, input logic [31:0] inst,
                                input logic e_inr, input logic e_idv,
                                input logic [63:0] e_pc, input logic [31:0] e_inst,
                                input logic [2:0] e_cnt, input logic e_stall);
        vec_t v;
        v.rst = r; v.iv = iv; v.fl = fl; v.idr = idr; v.pc = pc; v.inst = inst;
        v.e_inr = e_inr; v.e_idv = e_idv; v.e_pc = e_pc; v.e_inst = e_inst;
        v.e_cnt = e_cnt; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic fl, input logic idr,
                         input logic [63:0] pc, input logic [31:0] inst);
        rst = r; in_valid = iv; flush = fl; id_ready = idr; in_pc = pc; in_inst = inst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] q_pc[$];
    logic [31:0] q_inst[$];

    initial begin
        // Fields: rst iv fl idr pc inst | in_ready id_valid id_pc id_inst count stall
        // reset and idle
        vecs.push_back(mk(1,0,0,0, 64'h0, 32'h0,              1,0, 64'h0, 32'h0, 3'd0, 0));
        vecs.push_back(mk(0,0,0,0, 64'h0, 32'h0,              1,0, 64'h0, 32'h0, 3'd0, 1));
        // single pass-through
        vecs.push_back(mk(0,1,0,1, 64'h8000_0000, 32'h13,     1,0, 64'h0, 32'h0, 3'd0, 0));
        vecs.push_back(mk(0,0,0,1, 64'h0, 32'h0,              1,1, 64'h8000_0000, 32'h13, 3'd1, 0));
        vecs.push_back(mk(0,0,0,0, 64'h0, 32'h0,              1,0, 64'h0, 32'h0, 3'd0, 1));
        // fill to full, fifth push blocked even with id_ready, then drain in order
        vecs.push_back(mk(0,1,0,0, 64'h8000_0000, 32'h0010_0093, 1,0, 64'h0, 32'h0, 3'd0, 0));
        vecs.push_back(mk(0,1,0,0, 64'h8000_0004, 32'h0020_0113, 1,1, 64'h8000_0000, 32'h0010_0093, 3'd1, 0));
        vecs.push_back(mk(0,1,0,0, 64'h8000_0008, 32'h0030_0193, 1,1, 64'h8000_0000, 32'h0010_0093, 3'd2, 0));
        vecs.push_back(mk(0,1,0,0, 64'h8000_000C, 32'h0040_0213, 1,1, 64'h8000_0000, 32'h0010_0093, 3'd3, 0));
        vecs.push_back(mk(0,1,0,1, 64'h8000_0010, 32'h0050_0293, 0,1, 64'h8000_0000, 32'h0010_0093, 3'd4, 0));
        vecs.push_back(mk(0,0,0,1, 64'h0, 32'h0,              1,1, 64'h8000_0004, 32'h0020_0113, 3'd3, 0));
        vecs.push_back(mk(0,0,0,1, 64'h0, 32'h0,              1,1, 64'h8000_0008, 32'h0030_0193, 3'd2, 0));
        vecs.push_back(mk(0,0,0,1, 64'h0, 32'h0,              1,1, 64'h8000_000C, 32'h0040_0213, 3'd1, 0));
        vecs.push_back(mk(0,0,0,0, 64'h0, 32'h0,              1,0, 64'h0, 32'h0, 3'd0, 1));
        // simultaneous push and pop at count 2
        vecs.push_back(mk(0,1,0,0, 64'h9000_0000, 32'hA,      1,0, 64'h0, 32'h0, 3'd0, 0));
        vecs.push_back(mk(0,1,0,0, 64'h9000_0004, 32'hB,      1,1, 64'h9000_0000, 32'hA, 3'd1, 0));
        vecs.push_back(mk(0,1,0,1, 64'h9000_0008, 32'hC,      1,1, 64'h9000_0000, 32'hA, 3'd2, 0));
        vecs.push_back(mk(0,0,0,0, 64'h0, 32'h0,              1,1, 64'h9000_0004, 32'hB, 3'd2, 0));
        // flush at count 3 with push and pop requested
        vecs.push_back(mk(0,1,0,0, 64'h9000_000C, 32'hD,      1,1, 64'h9000_0004, 32'hB, 3'd2, 0));
        vecs.push_back(mk(0,1,1,1, 64'hDEAD_0000, 32'hE,      0,0, 64'h0, 32'h0, 3'd3, 0));
        vecs.push_back(mk(0,0,0,1, 64'h0, 32'h0,              1,0, 64'h0, 32'h0, 3'd0, 1));
        // reset at count 2
        vecs.push_back(mk(0,1,0,0, 64'hA000_0000, 32'h11,     1,0, 64'h0, 32'h0, 3'd0, 0));
        vecs.push_back(mk(0,1,0,0, 64'hA000_0004, 32'h12,     1,1, 64'hA000_0000, 32'h11, 3'd1, 0));
        vecs.push_back(mk(1,1,0,1, 64'hA000_0008, 32'h13,     1,1, 64'hA000_0000, 32'h11, 3'd2, 0));
        vecs.push_back(mk(0,0,0,0, 64'h0, 32'h0,              1,0, 64'h0, 32'h0, 3'd0, 1));

        drive(1, 0, 0, 0, 64'h0, 32'h0);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].fl, vecs[i].idr, vecs[i].pc, vecs[i].inst);
            @(negedge clk);
            check($sformatf("v%0d.in_ready", i), 64'(in_ready),        64'(vecs[i].e_inr));
            check($sformatf("v%0d.id_valid", i), 64'(id_valid),        64'(vecs[i].e_idv));
            check($sformatf("v%0d.id_pc", i),    id_pc,                vecs[i].e_pc);
            check($sformatf("v%0d.id_inst", i),  64'(id_inst),         64'(vecs[i].e_inst));
            check($sformatf("v%0d.count", i),    64'(count),           64'(vecs[i].e_cnt));
            check($sformatf("v%0d.stall", i),    64'(fetch_stall_req), 64'(vecs[i].e_stall));
            tick();
        end

        // Wrap-around: 10 pushes with id_ready toggling, checked against a FIFO model.
        begin
            int  pushed = 0;
            bit  e_push, e_pop;
            for (int cyc = 0; cyc < 60 && (pushed < 10 || q_pc.size() != 0); cyc++) begin
                drive(0, pushed < 10, 0, cyc[0], 64'hB000_0000 + 64'(pushed * 4), 32'h100 + 32'(pushed));
                @(negedge clk);
                check($sformatf("wrap%0d.count", cyc), 64'(count), 64'(q_pc.size()));
                check($sformatf("wrap%0d.id_valid", cyc), 64'(id_valid), 64'(q_pc.size() != 0));
                if (q_pc.size() != 0) begin
                    check($sformatf("wrap%0d.id_pc", cyc),   id_pc,        q_pc[0]);
                    check($sformatf("wrap%0d.id_inst", cyc), 64'(id_inst), 64'(q_inst[0]));
                end
                e_push = in_valid && (q_pc.size() < 4);
                e_pop  = (q_pc.size() != 0) && id_ready;
                if (e_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                end
                if (e_push) begin
                    q_pc.push_back(in_pc);
                    q_inst.push_back(in_inst);
                    pushed++;
                end
                tick();
            end
            drive(0, 0, 0, 0, 64'h0, 32'h0);
            @(negedge clk);
            check("wrap.final_count", 64'(count), 64'd0);
            tick();
        end

`ifdef IFQ_PERF_EN
        drive(1, 0, 0, 0, 64'h0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 64'h0, 32'h0);
        @(negedge clk);
        check("perf.full_after_rst",  64'(perf_full_cyc),  64'd0);
        check("perf.empty_after_rst", 64'(perf_empty_cyc), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 64'hC000_0000 + 64'(i * 4), 32'(i));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 64'hC000_0100, 32'hFF);
            tick();
        end
        @(negedge clk);
        check("perf.full_5", 64'(perf_full_cyc), 64'd5);
        drive(0, 1, 1, 0, 64'hC000_0100, 32'hFF);
        tick();
        drive(0, 0, 0, 1, 64'h0, 32'h0);
        @(negedge clk);
        check("perf.full_after_flush", 64'(perf_full_cyc), 64'd5);
        tick();
        drive(0, 0, 0, 0, 64'h0, 32'h0);
        @(negedge clk);
        check("perf.empty_1", 64'(perf_empty_cyc), 64'd1);
        drive(1, 0, 0, 0, 64'h0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 64'h0, 32'h0);
        @(negedge clk);
        check("perf.full_cleared",  64'(perf_full_cyc),  64'd0);
        check("perf.empty_cleared", 64'(perf_empty_cyc), 64'd0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
